// File: rtl/fwrisc_uart_pkg.sv
// fwrisc_uart_pkg: shared receiver state encoding and default loader constants
package fwrisc_uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_e;
    localparam int DEF_CLKS_PER_BIT = 868;
    localparam int DEF_PROG_BYTES   = 4096;
endpackage

// File: rtl/fwrisc_uart_rx_byte.sv
// fwrisc_uart_rx_byte: 8N1 UART byte receiver with rx synchroniser
// ports: clock/reset (sync, active-high), rx (async line), byte_valid (1-cycle pulse), byte_data (received byte)
module fwrisc_uart_rx_byte
    import fwrisc_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    logic          rx_m;
    logic          rx_s;
    rx_state_e     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic          tick;
    assign tick = cnt == CW'(CLKS_PER_BIT - 1);
    // byte_data doubles as the shift register; it is only consumed alongside byte_valid
    always_ff @(posedge clock) begin
        if (reset) begin
            {rx_s, rx_m} <= 2'b11;
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            byte_data    <= '0;
            byte_valid   <= 1'b0;
        end else begin
            {rx_s, rx_m} <= {rx_m, rx};
            byte_valid   <= 1'b0;
            cnt          <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: if (cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    state   <= rx_s ? IDLE : DATA;
                end
                DATA: if (tick) begin
                    cnt       <= '0;
                    byte_data <= {rx_s, byte_data[7:1]};
                    bit_idx   <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state <= STOP;
                end
                STOP: if (tick) begin
                    cnt        <= '0;
                    byte_valid <= rx_s;
                    state      <= rx_s ? IDLE : WAIT_IDLE;
                end
                WAIT_IDLE: begin
                    cnt <= '0;
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/fwrisc_uart_loader.sv
// fwrisc_uart_loader: UART program loader packing bytes into 32-bit words for instruction RAM
// ports: clock/reset (sync, active-high), rx (UART line), mem_we/mem_addr/mem_wdata (word write port),
//        program_receiving (pulse per accepted byte), program_done/program_ov (sticky), core_reset
module fwrisc_uart_loader
    import fwrisc_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int PROG_BYTES   = DEF_PROG_BYTES,
    parameter int ADDR_W       = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              program_receiving,
    output logic              program_done,
    output logic              program_ov,
    output logic              core_reset
);
    localparam int CNT_W = $clog2(PROG_BYTES) + 1;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic [CNT_W-1:0] byte_cnt;
    logic [23:0]      word;
    fwrisc_uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data)
    );
    // the fourth byte of a word goes straight to mem_wdata, so only three bytes are staged
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_we            <= 1'b0;
            mem_addr          <= '0;
            mem_wdata         <= '0;
            program_receiving <= 1'b0;
            program_done      <= 1'b0;
            program_ov        <= 1'b0;
            core_reset        <= 1'b1;
            byte_cnt          <= '0;
            word              <= '0;
        end else begin
            mem_we            <= 1'b0;
            program_receiving <= 1'b0;
            if (byte_valid) begin
                if (program_done) begin
                    program_ov <= 1'b1;
                end else begin
                    program_receiving <= 1'b1;
                    byte_cnt          <= byte_cnt + 1'b1;
                    if (byte_cnt[1:0] != 2'd3) word[{byte_cnt[1:0], 3'b000} +: 8] <= byte_data;
                    if (byte_cnt[1:0] == 2'd3) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= byte_cnt[ADDR_W+1:2];
                        mem_wdata <= {byte_data, word};
                    end
                    if (byte_cnt == CNT_W'(PROG_BYTES - 1)) begin
                        program_done <= 1'b1;
                        core_reset   <= 1'b0;
                    end
                end
            end
        end
    end
endmodule
